// File: rtl/emg_frame_packer.sv
// Packs serial per-channel ADC samples into one wide frame word. The frame goes out on a valid/ready slot.
// Optional framing-sync via FrameStart_SI is enabled by defining EMG_PACKER_SYNC_EN.
`timescale 1ns/1ps
module emg_frame_packer #(
  parameter int unsigned CHANNELS     = 64,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned FRAME_WIDTH  = CHANNELS * SAMPLE_WIDTH,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RI,
  input  logic                    SampleValid_SI,
  input  logic [SAMPLE_WIDTH-1:0] Sample_DI,
  input  logic                    FrameStart_SI,
  output logic                    ValidOut_SO,
  input  logic                    ReadyIn_SI,
  output logic [FRAME_WIDTH-1:0]  Frame_DO,
  output logic [CNT_WIDTH-1:0]    FrameCnt_DO,
  output logic [CNT_WIDTH-1:0]    DropCnt_DO,
  output logic                    SyncErr_SO
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  localparam logic [0:0] ST_FILL = 1'b0;
`ifdef EMG_PACKER_SYNC_EN
  localparam logic [0:0] ST_WAIT = 1'b1;
`endif

  logic [0:0]             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [FRAME_WIDTH-1:0] buf_q, buf_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   valid_q, valid_d;
  logic [CNT_WIDTH-1:0]   fcnt_q, fcnt_d;
  logic [CNT_WIDTH-1:0]   dcnt_q, dcnt_d;
  logic                   sync_err_q, sync_err_d;
  logic                   store;

  // State registers
  always_ff @(posedge Clk_CI or negedge Reset_RI) begin
    if (!Reset_RI) begin
      state_q    <= ST_FILL;
      idx_q      <= '0;
      buf_q      <= '0;
      frame_q    <= '0;
      valid_q    <= 1'b0;
      fcnt_q     <= '0;
      dcnt_q     <= '0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      frame_q    <= frame_d;
      valid_q    <= valid_d;
      fcnt_q     <= fcnt_d;
      dcnt_q     <= dcnt_d;
      sync_err_q <= sync_err_d;
    end
  end

  // Next-state: assembly, handoff, drop accounting
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    frame_d    = frame_q;
    valid_d    = valid_q;
    fcnt_d     = fcnt_q;
    dcnt_d     = dcnt_q;
    sync_err_d = 1'b0;
    store      = 1'b0;

    if (valid_q && ReadyIn_SI) valid_d = 1'b0;

    if (SampleValid_SI) begin
`ifdef EMG_PACKER_SYNC_EN
      if (state_q == ST_WAIT) begin
        if (FrameStart_SI) begin
          buf_d[SAMPLE_WIDTH-1:0] = Sample_DI;
          idx_d                   = IDX_W'(1);
          state_d                 = ST_FILL;
        end
      end else if (FrameStart_SI && (idx_q != '0)) begin
        // Early start marker: abandon the partial frame and restart on this beat
        sync_err_d              = 1'b1;
        buf_d[SAMPLE_WIDTH-1:0] = Sample_DI;
        idx_d                   = IDX_W'(1);
        if (dcnt_q != '1) dcnt_d = dcnt_q + CNT_WIDTH'(1);
      end else if (!FrameStart_SI && (idx_q == '0)) begin
        sync_err_d = 1'b1;
        state_d    = ST_WAIT;
      end else begin
        store = 1'b1;
      end
`else
      store = 1'b1;
`endif
    end

    if (store) begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (idx_q == IDX_W'(k)) buf_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = Sample_DI;
      end
      if (idx_q == IDX_LAST) begin
        idx_d = '0;
        // Slot is free if empty or being drained on this same edge
        if (!valid_q || ReadyIn_SI) begin
          frame_d = buf_d;
          valid_d = 1'b1;
          fcnt_d  = fcnt_q + CNT_WIDTH'(1);
        end else if (dcnt_q != '1) begin
          dcnt_d = dcnt_q + CNT_WIDTH'(1);
        end
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

`ifdef EMG_PACKER_SYNC_EN
  assign SyncErr_SO = sync_err_q;
`else
  logic unused_sync;
  assign unused_sync = FrameStart_SI | sync_err_q;
  assign SyncErr_SO  = 1'b0;
`endif

  assign ValidOut_SO = valid_q;
  assign Frame_DO    = frame_q;
  assign FrameCnt_DO = fcnt_q;
  assign DropCnt_DO  = dcnt_q;

endmodule
